mc_serial_rx: RTL and testbench

MC_SERIAL_RX -- requirements
Module: mc_serial_rx

---
 rtl/mc_serial_pkg.sv | 23 ++
 rtl/mc_serial_fifo.sv | 54 +++++
 rtl/mc_serial_rx.sv | 175 +++++++++++++++++
 tb/tb_mc_serial_rx.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/mc_serial_pkg.sv
// Shared types and constants for the bit-banged serial receiver.
// MC_SERIAL_RX_PARITY_EN adds an even-parity bit between data and stop.
package mc_serial_pkg;

  localparam int DATA_BITS = 8;
  localparam int CNT_W     = 3;
`ifdef MC_SERIAL_RX_PARITY_EN
  localparam int FRAME_EVENTS = 11;
`else
  localparam int FRAME_EVENTS = 10;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    STOP   = 2'd2
`ifdef MC_SERIAL_RX_PARITY_EN
    ,
    PARITY = 2'd3
`endif
  } rx_state_e;

endpackage

// File: rtl/mc_serial_fifo.sv
// Receive byte FIFO; pointers carry one extra wrap bit to tell full from empty.
// A push while full is accepted only when a pop happens in the same cycle.
module mc_serial_fifo
  import mc_serial_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push_i,
  input  logic [DATA_BITS-1:0] push_data_i,
  input  logic                 pop_i,
  output logic [DATA_BITS-1:0] pop_data_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]          wptr_q, wptr_d;
  logic [AW:0]          rptr_q, rptr_d;
  logic                 pop_ok, push_ok;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push_ok) wptr_d = wptr_q + 1'b1;
    if (pop_ok)  rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // When full, the write slot is the one being popped this cycle, so overwrite is safe.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q[AW-1:0]] <= push_data_i;
  end

  assign pop_data_o = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

endmodule

// File: rtl/mc_serial_rx.sv
// Bit-banged serial receiver: synchronised clock/data, framing FSM, byte FIFO.
// Define MC_SERIAL_RX_PARITY_EN to expect an even-parity bit before the stop bit.
module mc_serial_rx
  import mc_serial_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ser_clk,
  input  logic                 ser_data,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  input  logic                 err_clr,
  output logic                 frame_err,
  output logic                 overflow,
  output logic                 parity_err
);

  logic [SYNC_STAGES-1:0] sclk_q, sdat_q;
  logic                   sclk_prev_q;
  logic                   evt_q, bit_q;

  rx_state_e              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   push;
  logic                   ferr_set, ferr_q, ferr_d;
  logic                   ovf_set, ovf_q, ovf_d;
  logic                   fifo_full, fifo_empty;

  // Sync flops reset to 1 so a line held high through reset yields no edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sclk_q      <= '1;
      sdat_q      <= '1;
      sclk_prev_q <= 1'b1;
      evt_q       <= 1'b0;
      bit_q       <= 1'b1;
    end else begin
      sclk_q      <= {sclk_q[SYNC_STAGES-2:0], ser_clk};
      sdat_q      <= {sdat_q[SYNC_STAGES-2:0], ser_data};
      sclk_prev_q <= sclk_q[SYNC_STAGES-1];
      evt_q       <= sclk_q[SYNC_STAGES-1] & ~sclk_prev_q;
      bit_q       <= sdat_q[SYNC_STAGES-1];
    end
  end

`ifdef MC_SERIAL_RX_PARITY_EN
  logic perr_set, perr_q, perr_d;
  logic par_bad_q, par_bad_d;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    push     = 1'b0;
    ferr_set = 1'b0;
`ifdef MC_SERIAL_RX_PARITY_EN
    perr_set  = 1'b0;
    par_bad_d = par_bad_q;
`endif
    if (evt_q) begin
      case (state_q)
        IDLE: begin
          if (!bit_q) begin
            state_d = DATA;
            cnt_d   = '0;
`ifdef MC_SERIAL_RX_PARITY_EN
            par_bad_d = 1'b0;
`endif
          end
        end
        DATA: begin
          shift_d = {bit_q, shift_q[DATA_BITS-1:1]};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DATA_BITS - 1)) begin
`ifdef MC_SERIAL_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
`ifdef MC_SERIAL_RX_PARITY_EN
        PARITY: begin
          if (bit_q != ^shift_q) begin
            perr_set  = 1'b1;
            par_bad_d = 1'b1;
          end
          state_d = STOP;
        end
`endif
        STOP: begin
          if (bit_q) begin
`ifdef MC_SERIAL_RX_PARITY_EN
            push = ~par_bad_q;
`else
            push = 1'b1;
`endif
          end else begin
            ferr_set = 1'b1;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

  mc_serial_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (shift_q),
    .pop_i       (rx_ready),
    .pop_data_o  (rx_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign rx_valid = ~fifo_empty;
  assign ovf_set  = push & fifo_full & ~(rx_ready & ~fifo_empty);

  // A same-cycle set outranks err_clr.
  assign ferr_d = ferr_set | (ferr_q & ~err_clr);
  assign ovf_d  = ovf_set  | (ovf_q  & ~err_clr);

  always_ff @(posedge clk) begin
    if (!rst) begin
      ferr_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      ferr_q <= ferr_d;
      ovf_q  <= ovf_d;
    end
  end

  assign frame_err = ferr_q;
  assign overflow  = ovf_q;

`ifdef MC_SERIAL_RX_PARITY_EN
  assign perr_d = perr_set | (perr_q & ~err_clr);

  always_ff @(posedge clk) begin
    if (!rst) begin
      perr_q    <= 1'b0;
      par_bad_q <= 1'b0;
    end else begin
      perr_q    <= perr_d;
      par_bad_q <= par_bad_d;
    end
  end

  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_mc_serial_rx.sv
// Directed bench for mc_serial_rx: framing, latency, FIFO full/overflow, errors, reset.
// Parity cases are compiled in with MC_SERIAL_RX_PARITY_EN.
module tb_mc_serial_rx;

  localparam int SS = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ser_clk = 1'b0;
  logic       ser_data = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       err_clr = 1'b0;
  logic       frame_err, overflow, parity_err;

  int n_chk  = 0;
  int n_pass = 0;
  logic v_early, v_late;

  mc_serial_rx #(.FIFO_DEPTH(4), .SYNC_STAGES(SS)) dut (
    .clk        (clk),
    .rst        (rst),
    .ser_clk    (ser_clk),
    .ser_data   (ser_data),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .err_clr    (err_clr),
    .frame_err  (frame_err),
    .overflow   (overflow),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // One bit: data set up, ser_clk rise just after a clk edge. rx_valid is captured
  // at edges SS+1 (event registered) and SS+2 (event acted on); rdy/clr pulse at SS+2.
  task automatic send_bit(input logic b, input logic rdy, input logic clr);
    ser_data = b;
    repeat (3) @(posedge clk);
    #1 ser_clk = 1'b1;
    repeat (SS + 1) @(posedge clk);
    #1 v_early = rx_valid;
    rx_ready = rdy;
    err_clr  = clr;
    @(posedge clk);
    #1 v_late = rx_valid;
    rx_ready = 1'b0;
    err_clr  = 1'b0;
    repeat (3) @(posedge clk);
    #1 ser_clk = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip,
                            input logic rdy, input logic clr);
    send_bit(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i], 1'b0, 1'b0);
`ifdef MC_SERIAL_RX_PARITY_EN
    send_bit((^d) ^ par_flip, 1'b0, 1'b0);
`endif
    send_bit(stop, rdy, clr);
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    chk(tag, {23'd0, rx_valid, rx_data}, {23'd0, 1'b1, exp});
    rx_ready = 1'b1;
    @(posedge clk);
    #1 rx_ready = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", rx_valid, 1'b0);
    chk("rst_data", rx_data, 8'h00);
    chk("rst_ferr", frame_err, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_perr", parity_err, 1'b0);
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // 0x41 and first-valid latency relative to the stop edge
    send_frame(8'h41, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("lat_early", v_early, 1'b0);
    chk("lat_late", v_late, 1'b1);
    pop_chk("d41", 8'h41);
    chk("empty_after_pop", rx_valid, 1'b0);

    // Five frames into a depth-4 FIFO with no consumer
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0, 1'b0, 1'b0);
    chk("ovf_set", overflow, 1'b1);
    for (int i = 1; i <= 4; i++) pop_chk("ovf_hold", 8'(i));
    chk("ovf_empty", rx_valid, 1'b0);
    chk("ovf_still", overflow, 1'b1);
    pulse_clr();
    chk("ovf_clr", overflow, 1'b0);

    // Full FIFO, stop event coincident with a pop
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(8'h05, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("coinc_ovf", overflow, 1'b0);
    for (int i = 2; i <= 5; i++) pop_chk("coinc_data", 8'(i));
    chk("coinc_empty", rx_valid, 1'b0);

    // Framing error then recovery
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ferr_set", frame_err, 1'b1);
    chk("ferr_nopush", rx_valid, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("ferr_next", {23'd0, rx_valid, rx_data}, {23'd0, 1'b1, 8'h3C});
    pulse_clr();
    chk("ferr_clr", frame_err, 1'b0);
    pop_chk("d3c", 8'h3C);

    // err_clr in the same cycle as the error set: set wins
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("clr_prio", frame_err, 1'b1);

    // Reset mid-frame with a byte held and a flag set; ser_clk rises inside reset
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    ser_clk = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("mrst_valid", rx_valid, 1'b0);
    chk("mrst_data", rx_data, 8'h00);
    chk("mrst_ferr", frame_err, 1'b0);
    chk("mrst_ovf", overflow, 1'b0);
    chk("mrst_perr", parity_err, 1'b0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 ser_clk = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    send_frame(8'h7E, 1'b1, 1'b0, 1'b0, 1'b0);
    pop_chk("d7e", 8'h7E);
    chk("d7e_empty", rx_valid, 1'b0);

`ifdef MC_SERIAL_RX_PARITY_EN
    send_frame(8'h03, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("perr_set", parity_err, 1'b1);
    chk("perr_nopush", rx_valid, 1'b0);
    pulse_clr();
    chk("perr_clr", parity_err, 1'b0);
    send_frame(8'h03, 1'b1, 1'b0, 1'b0, 1'b0);
    pop_chk("d03", 8'h03);
    chk("perr_quiet", parity_err, 1'b0);
`else
    chk("perr_tied", parity_err, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
